// File: rtl/match_game_sm.sv
// match_game_sm: two-selection card-matching gameplay controller.
// Latches two card picks per turn, compares their face ids, writes matched
// cards back to board RAM with the matched flag set, holds mismatches
// face-up for SHOW_CYCLES clocks, and tracks per-player scores and pairs left.
// Optional feature macro: TWO_PLAYER_EN (defined -> two players alternate on
// a miss and Score1 is live; undefined -> single player, all credit to Score0).
module match_game_sm #(
  parameter int DATA_W      = 6,
  parameter int LOC_W       = 4,
  parameter int NUM_PAIRS   = 8,
  parameter int SHOW_CYCLES = 4,
  parameter int SCORE_W     = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Select,
  input  logic [DATA_W-1:0]  CardSelectData,
  input  logic [LOC_W-1:0]   CardSelectLoc,
  input  logic               Ack,
  output logic [7:0]         state,
  output logic               WriteEnable,
  output logic [LOC_W-1:0]   CARD1,
  output logic [LOC_W-1:0]   CARD2,
  output logic [DATA_W-1:0]  dataOut,
  output logic [LOC_W-1:0]   dataLoc,
  output logic               Player,
  output logic [SCORE_W-1:0] Score0,
  output logic [SCORE_W-1:0] Score1,
  output logic               MatchPulse
);

  localparam int FACE_W = DATA_W - 1;
  localparam int CNT_W  = $clog2(SHOW_CYCLES + 1);
  localparam int PL_W   = $clog2(NUM_PAIRS + 1);

  localparam logic [CNT_W-1:0]   SHOW_LD   = CNT_W'(SHOW_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PL_W-1:0]    PAIRS_LD  = PL_W'(NUM_PAIRS);
  localparam logic [PL_W-1:0]    PL_ONE    = PL_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  // One-hot encoding doubles as the externally visible state code.
  typedef enum logic [7:0] {
    S_INITIAL = 8'h01,
    S_FIRST   = 8'h02,
    S_SECOND  = 8'h04,
    S_COMPARE = 8'h08,
    S_MATCH   = 8'h10,
    S_MISS    = 8'h20,
    S_DONE    = 8'h40
  } state_t;

  // Saturating score increment: a full score stays at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s == SCORE_MAX) begin
      return s;
    end else begin
      return s + SCORE_ONE;
    end
  endfunction

  state_t              state_q,  state_d;
  logic [LOC_W-1:0]    card1_q,  card1_d;
  logic [LOC_W-1:0]    card2_q,  card2_d;
  logic [FACE_W-1:0]   face1_q,  face1_d;
  logic [FACE_W-1:0]   face2_q,  face2_d;
  logic                phase_q,  phase_d;   // 0: writing CARD1, 1: writing CARD2
  logic [CNT_W-1:0]    cnt_q,    cnt_d;     // mismatch display countdown
  logic [PL_W-1:0]     pairs_q,  pairs_d;   // pairs still face-down
  logic                player_q, player_d;
  logic [SCORE_W-1:0]  score0_q, score0_d;
  logic [SCORE_W-1:0]  score1_q, score1_d;
  logic                we_q,     we_d;
  logic [DATA_W-1:0]   dout_q,   dout_d;
  logic [LOC_W-1:0]    dloc_q,   dloc_d;
  logic                pulse_q,  pulse_d;

  logic                sel_ok_s;
  logic [FACE_W-1:0]   sel_face_s;

  assign sel_ok_s   = Select && !CardSelectData[DATA_W-1];
  assign sel_face_s = CardSelectData[DATA_W-2:0];

  // Next-state, datapath and look-ahead output computation.
  always_comb begin
    state_d  = state_q;
    card1_d  = card1_q;
    card2_d  = card2_q;
    face1_d  = face1_q;
    face2_d  = face2_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    pairs_d  = pairs_q;
    player_d = player_q;
    score0_d = score0_q;
    score1_d = score1_q;

    case (state_q)
      S_INITIAL: begin
        if (Start) begin
          state_d  = S_FIRST;
          score0_d = '0;
          score1_d = '0;
          player_d = 1'b0;
          pairs_d  = PAIRS_LD;
          card1_d  = '0;
          card2_d  = '0;
        end else begin
          state_d = S_INITIAL;
        end
      end
      S_FIRST: begin
        if (sel_ok_s) begin
          card1_d = CardSelectLoc;
          face1_d = sel_face_s;
          state_d = S_SECOND;
        end else begin
          state_d = S_FIRST;
        end
      end
      S_SECOND: begin
        // Re-picking the first card (including a held strobe) is rejected.
        if (sel_ok_s && (CardSelectLoc != card1_q)) begin
          card2_d = CardSelectLoc;
          face2_d = sel_face_s;
          state_d = S_COMPARE;
        end else begin
          state_d = S_SECOND;
        end
      end
      S_COMPARE: begin
        if (face1_q == face2_q) begin
          state_d = S_MATCH;
          phase_d = 1'b0;
        end else begin
          state_d = S_MISS;
          cnt_d   = SHOW_LD;
        end
      end
      S_MATCH: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          state_d = S_MATCH;
        end else begin
          phase_d = 1'b0;
          pairs_d = pairs_q - PL_ONE;
`ifdef TWO_PLAYER_EN
          if (player_q) begin
            score1_d = sat_inc(score1_q);
          end else begin
            score0_d = sat_inc(score0_q);
          end
`else
          score0_d = sat_inc(score0_q);
`endif
          if (pairs_q == PL_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_MISS: begin
        // Ack and expiry in the same cycle still give a single toggle.
        if (Ack || (cnt_q <= CNT_ONE)) begin
          state_d  = S_FIRST;
          cnt_d    = '0;
          player_d = ~player_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (Ack) begin
          state_d = S_INITIAL;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_INITIAL;
      end
    endcase

`ifndef TWO_PLAYER_EN
    player_d = 1'b0;
    score1_d = '0;
`endif

    // Outputs are computed for the state being entered so they are registered
    // yet aligned with the state code on the same cycle.
    we_d    = (state_d == S_MATCH);
    pulse_d = (state_q == S_COMPARE) && (state_d == S_MATCH);
    if (we_d) begin
      dloc_d = phase_d ? card2_q : card1_q;
      dout_d = {1'b1, face1_q};
    end else begin
      dloc_d = '0;
      dout_d = '0;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_INITIAL;
      card1_q  <= '0;
      card2_q  <= '0;
      face1_q  <= '0;
      face2_q  <= '0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      pairs_q  <= '0;
      player_q <= 1'b0;
      score0_q <= '0;
      score1_q <= '0;
      we_q     <= 1'b0;
      dout_q   <= '0;
      dloc_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      card1_q  <= card1_d;
      card2_q  <= card2_d;
      face1_q  <= face1_d;
      face2_q  <= face2_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      pairs_q  <= pairs_d;
      player_q <= player_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      we_q     <= we_d;
      dout_q   <= dout_d;
      dloc_q   <= dloc_d;
      pulse_q  <= pulse_d;
    end
  end

  assign state       = state_q;
  assign WriteEnable = we_q;
  assign CARD1       = card1_q;
  assign CARD2       = card2_q;
  assign dataOut     = dout_q;
  assign dataLoc     = dloc_q;
  assign Player      = player_q;
  assign Score0      = score0_q;
  assign Score1      = score1_q;
  assign MatchPulse  = pulse_q;

endmodule

// File: tb/tb_match_game_sm.sv
// Self-checking bench for match_game_sm: directed gameplay vectors, a
// behavioural game model compared against the DUT every cycle, and
// hand-computed literal expectations at key points.
module tb_match_game_sm;

  localparam int SHOW = 4;
`ifdef TWO_PLAYER_EN
  localparam bit TWO = 1'b1;
`else
  localparam bit TWO = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Select = 1'b0;
  logic [5:0] CardSelectData = 6'h00;
  logic [3:0] CardSelectLoc = 4'h0;
  logic       Ack = 1'b0;
  logic [7:0] state;
  logic       WriteEnable;
  logic [3:0] CARD1, CARD2, dataLoc;
  logic [5:0] dataOut;
  logic       Player;
  logic [3:0] Score0, Score1;
  logic       MatchPulse;

  int checks = 0;
  int errors = 0;

  match_game_sm #(
    .DATA_W(6), .LOC_W(4), .NUM_PAIRS(8), .SHOW_CYCLES(SHOW), .SCORE_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Select(Select),
    .CardSelectData(CardSelectData), .CardSelectLoc(CardSelectLoc), .Ack(Ack),
    .state(state), .WriteEnable(WriteEnable), .CARD1(CARD1), .CARD2(CARD2),
    .dataOut(dataOut), .dataLoc(dataLoc), .Player(Player),
    .Score0(Score0), .Score1(Score1), .MatchPulse(MatchPulse)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // mode: 0 idle, 1 first pick, 2 second pick, 3 compare, 4 writing, 5 showing, 6 over
  int         m_mode = 0;
  int         m_pairs = 0;
  int         m_wr_idx = 0;     // which card of the pair is being written
  int         m_shown = 0;      // cycles spent showing a mismatch
  logic [3:0] m_c1 = 4'h0, m_c2 = 4'h0;
  logic [4:0] m_f1 = 5'h00, m_f2 = 5'h00;
  logic       m_pl = 1'b0;
  int         m_s0 = 0, m_s1 = 0;
  bit         m_valid = 1'b0;

  task automatic model_step();
    if (Reset) begin
      m_mode = 0; m_pairs = 0; m_wr_idx = 0; m_shown = 0;
      m_c1 = 4'h0; m_c2 = 4'h0; m_pl = 1'b0; m_s0 = 0; m_s1 = 0;
      m_valid = 1'b1;
    end else begin
      case (m_mode)
        0: if (Start) begin
             m_mode = 1; m_s0 = 0; m_s1 = 0; m_pl = 1'b0; m_pairs = 8;
             m_c1 = 4'h0; m_c2 = 4'h0;
           end
        1: if (Select && !CardSelectData[5]) begin
             m_c1 = CardSelectLoc; m_f1 = CardSelectData[4:0]; m_mode = 2;
           end
        2: if (Select && !CardSelectData[5] && CardSelectLoc != m_c1) begin
             m_c2 = CardSelectLoc; m_f2 = CardSelectData[4:0]; m_mode = 3;
           end
        3: begin
             if (m_f1 == m_f2) begin m_mode = 4; m_wr_idx = 0; end
             else begin m_mode = 5; m_shown = 0; end
           end
        4: begin
             if (m_wr_idx == 0) m_wr_idx = 1;
             else begin
               m_wr_idx = 0;
               if (TWO && m_pl) begin if (m_s1 < 15) m_s1++; end
               else begin if (m_s0 < 15) m_s0++; end
               m_pairs--;
               m_mode = (m_pairs == 0) ? 6 : 1;
             end
           end
        5: begin
             m_shown++;
             if (Ack || m_shown >= SHOW) begin
               m_mode = 1;
               if (TWO) m_pl = ~m_pl;
             end
           end
        6: if (Ack) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    logic       e_we;
    logic [3:0] e_loc;
    logic [5:0] e_dout;
    e_we   = (m_mode == 4);
    e_loc  = e_we ? ((m_wr_idx == 1) ? m_c2 : m_c1) : 4'h0;
    e_dout = e_we ? {1'b1, m_f1} : 6'h00;
    check("state",       state,       8'h01 << m_mode);
    check("WriteEnable", WriteEnable, e_we);
    check("CARD1",       CARD1,       m_c1);
    check("CARD2",       CARD2,       m_c2);
    check("dataLoc",     dataLoc,     e_loc);
    check("dataOut",     dataOut,     e_dout);
    check("Player",      Player,      m_pl);
    check("Score0",      Score0,      m_s0);
    check("Score1",      Score1,      m_s1);
    check("MatchPulse",  MatchPulse,  (m_mode == 4) && (m_wr_idx == 0));
  endtask

  // Single compare process: advance the model on each edge, check just after.
  initial begin
    forever begin
      @(posedge Clk);
      model_step();
      #1;
      if (m_valid) compare_all();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic sel(input logic [3:0] loc, input logic [5:0] dat);
    CardSelectLoc = loc; CardSelectData = dat; Select = 1'b1;
    @(negedge Clk);
    Select = 1'b0;
  endtask

  task automatic start_game();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_state", state, 8'h01);
    check("rst_we", WriteEnable, 1'b0);
    check("rst_score0", Score0, 4'h0);
    Reset = 1'b0;
    start_game();
    check("start_state", state, 8'h02);

    // Matching pair at 2 and 9, face 5.
    sel(4'd2, 6'h05);
    check("first_pick", state, 8'h04);
    sel(4'd9, 6'h05);
    check("compare", state, 8'h08);
    tick();
    check("m0_state", state, 8'h10);
    check("m0_loc", dataLoc, 4'd2);
    check("m0_data", dataOut, 6'h25);
    check("m0_pulse", MatchPulse, 1'b1);
    tick();
    check("m1_loc", dataLoc, 4'd9);
    check("m1_we", WriteEnable, 1'b1);
    check("m1_pulse", MatchPulse, 1'b0);
    tick();
    check("after_match", state, 8'h02);
    check("score0_1", Score0, 4'h1);

    // Start outside INITIAL is ignored.
    start_game();
    check("start_ignored", Score0, 4'h1);

    // Mismatch held for SHOW cycles without Ack.
    sel(4'd3, 6'h04);
    sel(4'd7, 6'h06);
    for (int i = 0; i < SHOW; i++) begin
      tick();
      check("miss_hold", state, 8'h20);
      check("miss_no_we", WriteEnable, 1'b0);
    end
    tick();
    check("miss_exit", state, 8'h02);
    check("miss_player", Player, TWO);

    // Reselecting CARD1 or a matched card is ignored.
    sel(4'd4, 6'h03);
    sel(4'd4, 6'h03);
    check("reselect_card1", state, 8'h04);
    sel(4'd5, 6'h25);
    check("reselect_matched", state, 8'h04);
    sel(4'd5, 6'h03);
    repeat (3) tick();

    // Held select: second strobe cycle lands in SECOND and is rejected.
    CardSelectLoc = 4'd6; CardSelectData = 6'h01; Select = 1'b1;
    tick();
    tick();
    Select = 1'b0;
    check("held_select", state, 8'h04);
    sel(4'd8, 6'h02);
    tick();
    check("ack_miss", state, 8'h20);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("ack_exit", state, 8'h02);
    check("ack_player", Player, 1'b0);

    // Reset during MATCH cycle 0.
    sel(4'd10, 6'h07);
    sel(4'd11, 6'h07);
    tick();
    check("pre_reset_match", state, 8'h10);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_state", state, 8'h01);
    check("mid_rst_we", WriteEnable, 1'b0);
    check("mid_rst_s0", Score0, 4'h0);
    check("mid_rst_s1", Score1, 4'h0);

    // Full game, one mismatch before each pair after the first.
    start_game();
    for (int p = 0; p < 8; p++) begin
      if (p > 0) begin
        sel(4'(2 * p), 6'(p));
        sel(4'(2 * p + 1), 6'(p + 1));
        repeat (SHOW + 1) tick();
      end
      sel(4'(2 * p), 6'(p));
      sel(4'(2 * p + 1), 6'(p));
      repeat (3) tick();
    end
    check("done_state", state, 8'h40);
    check("done_total", 32'(Score0) + 32'(Score1), 32'd8);
    check("done_s0", Score0, TWO ? 4'd4 : 4'd8);
    sel(4'd0, 6'h00);
    check("done_sel_ignored", state, 8'h40);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("done_ack", state, 8'h01);
    tick();
    start_game();
    check("restart_clears", Score0, 4'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
